// File: rtl/flag_branch_unit_if.sv
// Signal bundle between the EX-stage pipeline and the flag/branch unit.
// The pipeline side uses the master modport and the unit uses the slave modport.
interface flag_branch_unit_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 ex_valid;
    logic                 ex_setflags;
    logic                 alu_negative;
    logic                 alu_zero;
    logic                 alu_carry_out;
    logic                 alu_overflow;
    logic                 stall;
    logic                 flush;
    logic                 br_valid;
    logic [1:0]           br_type;
    logic [3:0]           br_cond;
    logic [3:0]           flags_q;
    logic                 br_resolved;
    logic                 br_taken;
    logic [CNT_WIDTH-1:0] eval_count;
    logic [CNT_WIDTH-1:0] taken_count;

    modport master (
        output ex_valid, ex_setflags, alu_negative, alu_zero, alu_carry_out, alu_overflow,
        output stall, flush, br_valid, br_type, br_cond,
        input  flags_q, br_resolved, br_taken, eval_count, taken_count
    );

    modport slave (
        input  ex_valid, ex_setflags, alu_negative, alu_zero, alu_carry_out, alu_overflow,
        input  stall, flush, br_valid, br_type, br_cond,
        output flags_q, br_resolved, br_taken, eval_count, taken_count
    );
endinterface

// File: rtl/flag_branch_unit.sv
// NZCV flag register plus conditional-branch resolver with saturating statistics.
// B.cond sees the EX flag-setter's flags by forwarding; all outputs are registered.
module flag_branch_unit #(
    parameter int CNT_WIDTH = 16
) (
    input logic               clk,
    input logic               reset,
    flag_branch_unit_if.slave bus
);
    typedef enum logic [1:0] {
        BR_UNCOND = 2'b00,
        BR_COND   = 2'b01,
        BR_CBZ    = 2'b10,
        BR_CBNZ   = 2'b11
    } br_type_e;

    logic [3:0]           flags_r;
    logic                 br_resolved_r;
    logic                 br_taken_r;
    logic [CNT_WIDTH-1:0] eval_count_r;
    logic [CNT_WIDTH-1:0] taken_count_r;

    logic                 upd_s;
    logic                 fwd_s;
    logic                 ev_s;
    logic [3:0]           live_flags_s;
    logic [3:0]           eff_flags_s;
    logic                 taken_s;

    // Condition code evaluation against {N,Z,C,V}; NV behaves like AL.
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic res;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'h0:    res = z;
            4'h1:    res = ~z;
            4'h2:    res = c;
            4'h3:    res = ~c;
            4'h4:    res = n;
            4'h5:    res = ~n;
            4'h6:    res = v;
            4'h7:    res = ~v;
            4'h8:    res = c & ~z;
            4'h9:    res = ~c | z;
            4'hA:    res = (n == v);
            4'hB:    res = (n != v);
            4'hC:    res = ~z & (n == v);
            4'hD:    res = z | (n != v);
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    assign live_flags_s = {bus.alu_negative, bus.alu_zero, bus.alu_carry_out, bus.alu_overflow};
    assign fwd_s        = bus.ex_valid & bus.ex_setflags & ~bus.flush;
    assign upd_s        = fwd_s & ~bus.stall;
    assign ev_s         = bus.br_valid & ~bus.stall & ~bus.flush;

    // Effective flags and branch direction for the branch presented this cycle.
    always_comb begin
        eff_flags_s = flags_r;
        taken_s     = 1'b0;
        if (fwd_s) begin
            eff_flags_s = live_flags_s;
        end else begin
            eff_flags_s = flags_r;
        end
        case (br_type_e'(bus.br_type))
            BR_UNCOND: taken_s = 1'b1;
            BR_COND:   taken_s = cond_holds(bus.br_cond, eff_flags_s);
            BR_CBZ:    taken_s = bus.alu_zero;
            BR_CBNZ:   taken_s = ~bus.alu_zero;
            default:   taken_s = 1'b1;
        endcase
    end

    // Architectural flags, resolution pulse, direction and saturating counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_r       <= 4'b0000;
            br_resolved_r <= 1'b0;
            br_taken_r    <= 1'b0;
            eval_count_r  <= {CNT_WIDTH{1'b0}};
            taken_count_r <= {CNT_WIDTH{1'b0}};
        end else begin
            br_resolved_r <= ev_s;
            if (upd_s) begin
                flags_r <= live_flags_s;
            end
            if (ev_s) begin
                br_taken_r <= taken_s;
                if (eval_count_r != {CNT_WIDTH{1'b1}}) begin
                    eval_count_r <= eval_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
                if (taken_s && (taken_count_r != {CNT_WIDTH{1'b1}})) begin
                    taken_count_r <= taken_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign bus.flags_q     = flags_r;
    assign bus.br_resolved = br_resolved_r;
    assign bus.br_taken    = br_taken_r;
    assign bus.eval_count  = eval_count_r;
    assign bus.taken_count = taken_count_r;
endmodule
